instr_fetch_unit: RTL and testbench

- Front-end stage directly upstream of the Cpu decode/execute path.
- Issues pipelined instruction reads on an Avalon-MM read host port and buffers returned words with their PCs in a prefetch FIFO.
- Presents instructions to the core over a valid/ready handshake.
- Handles branch/jump redirects by flushing the FIFO and discarding stale in-flight responses.

---
 rtl/instr_fetch_unit.sv | 142 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front-end: pipelined Avalon-MM reads into a PC-tagged prefetch FIFO,
// valid/ready delivery to the core, and redirect handling that drops stale responses.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          FIFO_DEPTH      = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } fetch_entry_t;

    fetch_entry_t   mem [FIFO_DEPTH];
    fetch_entry_t   head;
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  fifo_count, fifo_count_n;

    logic [31:0]    fetch_pc, fetch_pc_n;
    logic [31:0]    resp_pc, resp_pc_n;
    logic [31:0]    addr_q;
    logic [31:0]    redirect_tgt;
    logic           cmd_q, held_q;
    logic           stalled_stale, stalled_stale_n;
    logic [OW-1:0]  outstanding, outstanding_n;
    logic [OW-1:0]  discard, discard_n;
    logic [OW-1:0]  live_after, disc_after;

    logic           accept, hold, can_issue;
    logic           resp_ok, resp_disc, resp_live;
    logic           acc_live, acc_stale;
    logic           push, pop;

    assign redirect_tgt = redirect_pc & ~32'h3;

    // A command already held on waitrequest must persist; a fresh one is dropped on redirect.
    assign avm_read    = cmd_q & (held_q | ~redirect_valid);
    assign avm_address = addr_q;
    assign accept      = avm_read & ~avm_waitrequest;
    assign hold        = avm_read & avm_waitrequest;

    assign resp_ok   = avm_readdatavalid && (outstanding != '0 || discard != '0);
    assign resp_disc = resp_ok && (discard != '0);
    assign resp_live = resp_ok && (discard == '0);
    assign acc_stale = accept && (stalled_stale || redirect_valid);
    assign acc_live  = accept && !acc_stale;

    assign push       = resp_live && !redirect_valid;
    assign inst_valid = (fifo_count != '0) && !redirect_valid;
    assign pop        = inst_valid && inst_ready;

    assign head      = mem[rd_ptr];
    assign inst_data = head.data;
    assign inst_pc   = head.pc;

    always_comb begin
        live_after = outstanding - OW'(resp_live) + OW'(acc_live);
        disc_after = discard - OW'(resp_disc) + OW'(acc_stale);

        // On redirect every live read becomes a read to discard.
        outstanding_n = redirect_valid ? '0 : live_after;
        discard_n     = redirect_valid ? (disc_after + live_after) : disc_after;

        fifo_count_n    = redirect_valid ? '0 : (fifo_count + CW'(push) - CW'(pop));
        stalled_stale_n = hold && (stalled_stale || redirect_valid);

        fetch_pc_n = fetch_pc;
        if (redirect_valid)
            fetch_pc_n = redirect_tgt;
        else if (acc_live)
            fetch_pc_n = fetch_pc + 32'd4;

        resp_pc_n = resp_pc;
        if (redirect_valid)
            resp_pc_n = redirect_tgt;
        else if (push)
            resp_pc_n = resp_pc + 32'd4;

        // Credit check on next-cycle state: each live read owns a FIFO slot.
        can_issue = (int'(fifo_count_n) + int'(outstanding_n) < FIFO_DEPTH) &&
                    (int'(outstanding_n) + int'(discard_n) < MAX_OUTSTANDING);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc      <= RESET_PC;
            resp_pc       <= RESET_PC;
            addr_q        <= RESET_PC;
            cmd_q         <= 1'b0;
            held_q        <= 1'b0;
            stalled_stale <= 1'b0;
            outstanding   <= '0;
            discard       <= '0;
            fifo_count    <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
        end else begin
            fetch_pc      <= fetch_pc_n;
            resp_pc       <= resp_pc_n;
            held_q        <= hold;
            stalled_stale <= stalled_stale_n;
            outstanding   <= outstanding_n;
            discard       <= discard_n;
            fifo_count    <= fifo_count_n;
            if (!hold) begin
                cmd_q  <= can_issue;
                addr_q <= fetch_pc_n;
            end
            if (redirect_valid) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= '{pc: resp_pc, data: avm_readdata};
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: Avalon read agent with programmable latency,
// pop monitor, and a linear sequence of fetch/stall/redirect/wrap/reset scenarios.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_waitrequest = 1'b0;
    logic [31:0] avm_readdata = 32'h0;
    logic        avm_readdatavalid = 1'b0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;

    instr_fetch_unit #(
        .RESET_PC(32'h0000_0000), .FIFO_DEPTH(4), .MAX_OUTSTANDING(2)
    ) dut (
        .clk(clk), .rst(rst),
        .avm_address(avm_address), .avm_read(avm_read),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_data(inst_data), .inst_pc(inst_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int lat = 1;
    int acc_cnt = 0;

    typedef struct { logic [31:0] addr; int due; } rsp_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; int cyc; } pop_t;
    rsp_t rq[$];
    pop_t got[$];

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] gpc(input int i);
        return (i < got.size()) ? got[i].pc : 32'hxxxx_xxxx;
    endfunction

    // Avalon agent: responds in order, lat cycles after acceptance, data = addr + 0x13.
    logic        prev_held = 1'b0;
    logic [31:0] prev_addr = 32'h0;
    always @(negedge clk) begin
        if (!rst) begin
            rq.delete();
            avm_readdatavalid = 1'b0;
            prev_held = 1'b0;
        end else begin
            if (rq.size() > 0 && rq[0].due <= cyc) begin
                avm_readdatavalid = 1'b1;
                avm_readdata = rq[0].addr + 32'h13;
                void'(rq.pop_front());
            end else begin
                avm_readdatavalid = 1'b0;
                avm_readdata = 32'h0;
            end
            #3;
            if (rst) begin
                if (prev_held) begin
                    chk("hold_read", {31'b0, avm_read}, 32'd1);
                    chk("hold_addr", avm_address, prev_addr);
                end
                if (avm_read) chk("addr_align", {30'b0, avm_address[1:0]}, 32'd0);
                if (avm_read && !avm_waitrequest) begin
                    rq.push_back('{addr: avm_address, due: cyc + lat});
                    acc_cnt++;
                end
                prev_held = avm_read && avm_waitrequest;
                prev_addr = avm_address;
            end
        end
    end

    // Pop monitor: every delivered instruction must carry the word fetched from its own PC.
    always @(negedge clk) begin
        #4;
        if (rst) begin
            if (dut.push) chk("fifo_overflow", {31'b0, dut.fifo_count == 3'd4}, 32'd0);
            if (inst_valid && inst_ready) begin
                got.push_back('{pc: inst_pc, data: inst_data, cyc: cyc});
                chk("pop_data", inst_data, inst_pc + 32'h13);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        redirect_valid = 1'b0;
        avm_waitrequest = 1'b0;
        tick();
        tick();
        #1;
        chk("rst_avm_read", {31'b0, avm_read}, 32'd0);
        chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst_avm_address", avm_address, 32'h0);
        got.delete();
        acc_cnt = 0;
        tick();
        rst = 1'b1;
        #1;
        chk("rel_no_comb_read", {31'b0, avm_read}, 32'd0);
    endtask

    task automatic wait_pops(input int n, input int budget, input string tag);
        int k = 0;
        while (got.size() < n && k < budget) begin
            tick();
            k++;
        end
        n_cmp++;
        assert (got.size() >= n) else begin
            n_bad++;
            $error("FAIL %s_timeout: observed %0d pops expected %0d", tag, got.size(), n);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: streaming, zero wait, 1-cycle latency
        inst_ready = 1'b1;
        lat = 1;
        do_reset();
        wait_pops(4, 20, "t1");
        chk("t1_pc0", gpc(0), 32'h0);
        chk("t1_pc1", gpc(1), 32'h4);
        chk("t1_pc2", gpc(2), 32'h8);
        chk("t1_pc3", gpc(3), 32'hC);
        chk("t1_rate", (got.size() >= 4) ? 32'(got[3].cyc - got[0].cyc) : 32'hFFFF_FFFF, 32'd3);

        // 2: core stalled -> FIFO fills to depth, fetch stops
        inst_ready = 1'b0;
        do_reset();
        repeat (12) tick();
        chk("t2_read_off", {31'b0, avm_read}, 32'd0);
        chk("t2_accepts", 32'(acc_cnt), 32'd4);
        chk("t2_valid", {31'b0, inst_valid}, 32'd1);
        chk("t2_head_pc", inst_pc, 32'h0);
        chk("t2_head_data", inst_data, 32'h13);
        inst_ready = 1'b1;
        wait_pops(5, 30, "t2");
        for (int i = 0; i < 5; i++) chk("t2_pc", gpc(i), 32'(4 * i));

        // 3: waitrequest held three cycles on address 8
        do_reset();
        for (int k = 0; k < 10; k++) begin
            tick();
            if (avm_read && avm_address == 32'h8) break;
        end
        chk("t3_found_addr8", avm_address, 32'h8);
        avm_waitrequest = 1'b1;
        #1;
        chk("t3_w1_read", {31'b0, avm_read}, 32'd1);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("t3_w_read", {31'b0, avm_read}, 32'd1);
            chk("t3_w_addr", avm_address, 32'h8);
        end
        tick();
        avm_waitrequest = 1'b0;
        #1;
        chk("t3_acc_addr", avm_address, 32'h8);
        tick();
        chk("t3_next_read", {31'b0, avm_read}, 32'd1);
        chk("t3_next_addr", avm_address, 32'hC);
        wait_pops(5, 30, "t3");
        for (int i = 0; i < 5; i++) chk("t3_pc", gpc(i), 32'(4 * i));

        // 4: redirect with two reads in flight
        lat = 3;
        do_reset();
        tick();
        chk("t4_c0_addr", avm_address, 32'h0);
        tick();
        chk("t4_c1_addr", avm_address, 32'h4);
        tick();
        chk("t4_c2_read_off", {31'b0, avm_read}, 32'd0);
        redirect_valid = 1'b1;
        redirect_pc = 32'h103;
        #1;
        chk("t4_redir_valid", {31'b0, inst_valid}, 32'd0);
        tick();
        redirect_valid = 1'b0;
        wait_pops(2, 30, "t4");
        chk("t4_pc0", gpc(0), 32'h100);
        chk("t4_pc1", gpc(1), 32'h104);
        chk("t4_data0", (got.size() > 0) ? got[0].data : 32'hxxxx_xxxx, 32'h113);

        // 5: redirect coinciding with a response and a ready core
        lat = 1;
        do_reset();
        tick();
        tick();
        tick();
        chk("t5_pre_valid", {31'b0, inst_valid}, 32'd1);
        chk("t5_pre_pc", inst_pc, 32'h0);
        chk("t5_rdv", {31'b0, avm_readdatavalid}, 32'd1);
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        #1;
        chk("t5_redir_valid", {31'b0, inst_valid}, 32'd0);
        chk("t5_redir_read", {31'b0, avm_read}, 32'd0);
        tick();
        redirect_valid = 1'b0;
        wait_pops(1, 20, "t5");
        chk("t5_pc0", gpc(0), 32'h200);

        // 6: address wrap, then reset mid-burst
        do_reset();
        repeat (5) tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        #1;
        got.delete();
        tick();
        redirect_valid = 1'b0;
        wait_pops(3, 20, "t6");
        chk("t6_pc0", gpc(0), 32'hFFFF_FFF8);
        chk("t6_pc1", gpc(1), 32'hFFFF_FFFC);
        chk("t6_pc2", gpc(2), 32'h0000_0000);
        chk("t6_burst_read", {31'b0, avm_read}, 32'd1);
        chk("t6_burst_valid", {31'b0, inst_valid}, 32'd1);
        rst = 1'b0;
        #1;
        chk("t6_rst_read", {31'b0, avm_read}, 32'd0);
        chk("t6_rst_valid", {31'b0, inst_valid}, 32'd0);
        do_reset();
        wait_pops(2, 20, "t6r");
        chk("t6r_pc0", gpc(0), 32'h0);
        chk("t6r_pc1", gpc(1), 32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
